// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM state encoding,
// datapath widths, PC increment and word-alignment helper.
package fetch_unit_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 64;

  localparam logic [PC_W-1:0] PC_INC        = 64'd4;
  localparam logic [PC_W-1:0] PC_ALIGN_MASK = {{(PC_W-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  // Instructions are word aligned, so the two low bits of any loaded PC are dropped.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc_in);
    return pc_in & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_outbuf.sv
// Output holding register for the fetch unit: captures one instruction and its PC,
// presents it with a valid flag until cleared.
module fetch_outbuf
  import fetch_unit_pkg::*;
(
  input  logic               CLK,
  input  logic               resetl,
  input  logic               load,
  input  logic               clear,
  input  logic [INSTR_W-1:0] load_data,
  input  logic [PC_W-1:0]    load_pc,
  output logic               valid,
  output logic [INSTR_W-1:0] data,
  output logic [PC_W-1:0]    pc
);

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      valid <= 1'b0;
      data  <= '0;
      pc    <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      pc    <= load_pc;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding-request instruction fetch unit (REQ -> WAIT -> HOLD).
// Define FETCH_ALIGN_CHECK_EN to flag misaligned redirects and halt fetching.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 64'h0
) (
  input  logic               CLK,
  input  logic               resetl,
  input  logic               Redirect,
  input  logic [PC_W-1:0]    RedirectPC,
  output logic               IMemReq,
  output logic [PC_W-1:0]    IMemAddr,
  input  logic               IMemGnt,
  input  logic               IMemRvalid,
  input  logic [INSTR_W-1:0] IMemRdata,
  output logic               InstrValid,
  input  logic               InstrReady,
  output logic [INSTR_W-1:0] Instr,
  output logic [PC_W-1:0]    InstrPC,
  output logic               MisalignErr
);

  fetch_state_t    state;
  logic [PC_W-1:0] pc;
  logic            drop;
  logic            req;
  logic            misalign_err;
  logic            halt;
  logic [PC_W-1:0] redirect_pc;
  logic            buf_load;
  logic            buf_clear;

  assign redirect_pc = align_pc(RedirectPC);

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_now;
  assign misalign_now = Redirect && (RedirectPC[1:0] != 2'b00);

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      misalign_err <= 1'b0;
    end else if (misalign_now) begin
      misalign_err <= 1'b1;
    end
  end

  // Any request already granted still drains; halt only gates new requests.
  assign halt = misalign_err | misalign_now;
`else
  assign misalign_err = 1'b0;
  assign halt         = 1'b0;
`endif

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state <= REQ;
      pc    <= RESET_PC;
      drop  <= 1'b0;
      req   <= 1'b0;
    end else begin
      case (state)
        REQ: begin
          if (req && IMemGnt) begin
            state <= WAIT;
            req   <= 1'b0;
            if (Redirect) drop <= 1'b1;
          end else begin
            req <= !halt;
          end
          if (Redirect) pc <= redirect_pc;
        end
        WAIT: begin
          if (Redirect) pc <= redirect_pc;
          if (IMemRvalid) begin
            // A response racing a redirect belongs to the stale path.
            if (drop || Redirect) begin
              state <= REQ;
              drop  <= 1'b0;
              req   <= !halt;
            end else begin
              state <= HOLD;
              pc    <= pc + PC_INC;
            end
          end else if (Redirect) begin
            drop <= 1'b1;
          end
        end
        HOLD: begin
          if (Redirect || InstrReady) begin
            state <= REQ;
            req   <= !halt;
            if (Redirect) pc <= redirect_pc;
          end
        end
        default: begin
          state <= REQ;
          req   <= 1'b0;
          drop  <= 1'b0;
        end
      endcase
    end
  end

  assign buf_load  = (state == WAIT) && IMemRvalid && !drop && !Redirect;
  assign buf_clear = (state == HOLD) && (Redirect || InstrReady);

  fetch_outbuf u_outbuf (
    .CLK       (CLK),
    .resetl    (resetl),
    .load      (buf_load),
    .clear     (buf_clear),
    .load_data (IMemRdata),
    .load_pc   (pc),
    .valid     (InstrValid),
    .data      (Instr),
    .pc        (InstrPC)
  );

  assign IMemReq     = req;
  assign IMemAddr    = pc;
  assign MisalignErr = misalign_err;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: accepted responses are queued as
// expected instructions and compared when the DUT presents them.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        resetl;
  logic        Redirect;
  logic [63:0] RedirectPC;
  logic        IMemReq;
  logic [63:0] IMemAddr;
  logic        IMemGnt;
  logic        IMemRvalid;
  logic [31:0] IMemRdata;
  logic        InstrValid;
  logic        InstrReady;
  logic [31:0] Instr;
  logic [63:0] InstrPC;
  logic        MisalignErr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } exp_t;
  exp_t sb[$];

  always #5 CLK = ~CLK;

  fetch_unit #(.RESET_PC(64'h1000)) dut (
    .CLK        (CLK),
    .resetl     (resetl),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .IMemReq    (IMemReq),
    .IMemAddr   (IMemAddr),
    .IMemGnt    (IMemGnt),
    .IMemRvalid (IMemRvalid),
    .IMemRdata  (IMemRdata),
    .InstrValid (InstrValid),
    .InstrReady (InstrReady),
    .Instr      (Instr),
    .InstrPC    (InstrPC),
    .MisalignErr(MisalignErr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Wait (bounded) for a request, check its address, grant it for one cycle.
  task automatic grant(input string tag, input logic [63:0] addr);
    for (int i = 0; i < 20 && !IMemReq; i++) step();
    chk({tag, "_req"}, {63'd0, IMemReq}, 64'd1);
    chk({tag, "_addr"}, IMemAddr, addr);
    $display("grant   %s addr=%h", tag, IMemAddr);
    IMemGnt = 1'b1;
    step();
    IMemGnt = 1'b0;
  endtask

  task automatic respond(input logic [31:0] data, input logic [63:0] pc, input bit keep);
    exp_t e;
    IMemRvalid = 1'b1;
    IMemRdata  = data;
    if (keep) begin
      e.instr = data;
      e.pc    = pc;
      sb.push_back(e);
    end
    $display("respond data=%h keep=%0d", data, keep);
    step();
    IMemRvalid = 1'b0;
    IMemRdata  = '0;
  endtask

  // Compare the presented instruction against the oldest expected one.
  task automatic check_out(input string tag);
    exp_t e;
    chk({tag, "_valid"}, {63'd0, InstrValid}, 64'd1);
    chk({tag, "_sb_nonempty"}, {63'd0, sb.size() != 0}, 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_instr"}, {32'd0, Instr}, {32'd0, e.instr});
      chk({tag, "_pc"}, InstrPC, e.pc);
      $display("instr   %s instr=%h pc=%h", tag, Instr, InstrPC);
    end
  endtask

  task automatic consume();
    InstrReady = 1'b1;
    step();
    InstrReady = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    resetl = 1'b0; Redirect = 1'b0; RedirectPC = '0; IMemGnt = 1'b0;
    IMemRvalid = 1'b0; IMemRdata = '0; InstrReady = 1'b0;
    #2;
    chk("rst_req", {63'd0, IMemReq}, 64'd0);
    chk("rst_valid", {63'd0, InstrValid}, 64'd0);
    chk("rst_instr", {32'd0, Instr}, 64'd0);
    chk("rst_instrpc", InstrPC, 64'd0);
    chk("rst_misalign", {63'd0, MisalignErr}, 64'd0);
    step(); step();
    resetl = 1'b1;
    chk("rel_req_low", {63'd0, IMemReq}, 64'd0);
    step();
    chk("rel_req_high", {63'd0, IMemReq}, 64'd1);

    // Minimum-latency fetch from the reset PC.
    grant("f0", 64'h1000);
    chk("f0_wait_noreq", {63'd0, IMemReq}, 64'd0);
    respond(32'hD503201F, 64'h1000, 1'b1);
    check_out("f0");

    // Decode stalls for five cycles: everything stays put.
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_valid", {63'd0, InstrValid}, 64'd1);
      chk("hold_instr", {32'd0, Instr}, 64'hD503201F);
      chk("hold_pc", InstrPC, 64'h1000);
      chk("hold_noreq", {63'd0, IMemReq}, 64'd0);
    end
    consume();
    chk("rel_valid", {63'd0, InstrValid}, 64'd0);
    chk("next_req", {63'd0, IMemReq}, 64'd1);
    chk("next_addr", IMemAddr, 64'h1004);

    // Stray response with nothing outstanding; request held without a grant.
    IMemRvalid = 1'b1; IMemRdata = 32'hDEADBEEF;
    step();
    IMemRvalid = 1'b0;
    chk("stray_valid", {63'd0, InstrValid}, 64'd0);
    step();
    chk("nognt_req", {63'd0, IMemReq}, 64'd1);
    chk("nognt_addr", IMemAddr, 64'h1004);

    // Redirect while waiting: the response is discarded.
    grant("f1", 64'h1004);
    Redirect = 1'b1; RedirectPC = 64'h2000;
    step();
    Redirect = 1'b0;
    chk("rw_noreq", {63'd0, IMemReq}, 64'd0);
    step();
    respond(32'hAAAAAAAA, 64'h0, 1'b0);
    chk("rw_valid", {63'd0, InstrValid}, 64'd0);
    chk("rw_addr", IMemAddr, 64'h2000);

    // Redirect beats InstrReady in HOLD.
    grant("f2", 64'h2000);
    respond(32'h11111111, 64'h2000, 1'b1);
    check_out("f2");
    Redirect = 1'b1; RedirectPC = 64'h3000; InstrReady = 1'b1;
    step();
    Redirect = 1'b0; InstrReady = 1'b0;
    chk("rh_valid", {63'd0, InstrValid}, 64'd0);
    chk("rh_addr", IMemAddr, 64'h3000);

    // Redirect coincident with a grant: the granted response is dropped.
    Redirect = 1'b1; RedirectPC = 64'h4000; IMemGnt = 1'b1;
    step();
    Redirect = 1'b0; IMemGnt = 1'b0;
    chk("rg_noreq", {63'd0, IMemReq}, 64'd0);
    respond(32'h22222222, 64'h0, 1'b0);
    chk("rg_valid", {63'd0, InstrValid}, 64'd0);
    chk("rg_addr", IMemAddr, 64'h4000);

    // Two redirects while waiting: only one response discarded.
    grant("f3", 64'h4000);
    Redirect = 1'b1; RedirectPC = 64'h5000;
    step();
    RedirectPC = 64'h6001;
    step();
    Redirect = 1'b0;
    respond(32'h33333333, 64'h0, 1'b0);
    chk("rr_valid", {63'd0, InstrValid}, 64'd0);
    grant("f4", 64'h6000);
    respond(32'h44444444, 64'h6000, 1'b1);
    check_out("f4");
    consume();

    // PC wraps past the top of the address space.
    Redirect = 1'b1; RedirectPC = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    Redirect = 1'b0;
    grant("f5", 64'hFFFF_FFFF_FFFF_FFFC);
    respond(32'h55555555, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
    check_out("f5");
    consume();
    chk("wrap_addr", IMemAddr, 64'h0);

    // Reset while a request is outstanding, then a stray response.
    grant("f6", 64'h0);
    resetl = 1'b0;
    #1;
    chk("mrst_req", {63'd0, IMemReq}, 64'd0);
    chk("mrst_valid", {63'd0, InstrValid}, 64'd0);
    step();
    resetl = 1'b1;
    IMemRvalid = 1'b1; IMemRdata = 32'hBADBAD00;
    step();
    IMemRvalid = 1'b0;
    chk("mrst_stray_valid", {63'd0, InstrValid}, 64'd0);
    chk("mrst_instr", {32'd0, Instr}, 64'd0);
    chk("mrst_req_after", {63'd0, IMemReq}, 64'd1);
    chk("mrst_addr", IMemAddr, 64'h1000);

    // Misaligned redirect.
    Redirect = 1'b1; RedirectPC = 64'h2002;
    step();
    Redirect = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    chk("mis_err", {63'd0, MisalignErr}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      chk("mis_noreq", {63'd0, IMemReq}, 64'd0);
      step();
    end
`else
    chk("mis_err", {63'd0, MisalignErr}, 64'd0);
    chk("mis_req", {63'd0, IMemReq}, 64'd1);
    chk("mis_addr", IMemAddr, 64'h2000);
`endif
    $display("misalign err=%0d req=%0d addr=%h", MisalignErr, IMemReq, IMemAddr);

    chk("sb_drained", {32'd0, sb.size()}, 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 64'h0, SHALL give the PC value loaded by reset.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 CLK  in  1  rising-edge clock for all state.
REQ-004 resetl  in  1  asynchronous active-low reset.
REQ-005 Redirect  in  1  branch/jump taken this cycle; RedirectPC valid.
REQ-006 RedirectPC  in  64  target PC from next-PC logic.
REQ-007 IMemReq  out  1  fetch request to instruction memory.
REQ-008 IMemAddr  out  64  fetch address, valid while IMemReq=1.
REQ-009 IMemGnt  in  1  memory accepted request this cycle.
REQ-010 IMemRvalid  in  1  read data valid.
REQ-011 IMemRdata  in  32  instruction word.
REQ-012 InstrValid  out  1  Instr/InstrPC hold a fetched instruction.
REQ-013 InstrReady  in  1  decode consumes instruction when InstrValid=1.
REQ-014 Instr  out  32  fetched instruction.
REQ-015 InstrPC  out  64  address Instr was fetched from.
REQ-016 MisalignErr  out  1  sticky misaligned-redirect flag (only with macro, REQ-034).

Function
REQ-017 States SHALL be REQ, WAIT, HOLD; at most one memory request outstanding.
REQ-018 REQ: IMemReq=1, IMemAddr=PC; IMemGnt=1 -> WAIT; otherwise stay, request and address held stable.
REQ-019 WAIT: IMemReq=0; IMemRvalid=1 -> capture Instr=IMemRdata, InstrPC=PC, InstrValid=1, PC=PC+4 (mod 2^64), go HOLD.
REQ-020 HOLD: InstrValid=1, outputs stable; InstrReady=1 -> InstrValid=0 next cycle, go REQ.
REQ-021 Minimum latency SHALL be: request issued, granted same cycle, Rvalid next cycle -> InstrValid asserted the cycle after Rvalid.
REQ-022 Redirect in REQ: PC=RedirectPC next cycle, stay REQ; if IMemGnt also 1 same cycle, request counts as granted and a drop flag is set.
REQ-023 Redirect in WAIT: PC=RedirectPC, set drop flag; next IMemRvalid SHALL be discarded (no InstrValid), flag cleared, go REQ.
REQ-024 Redirect in HOLD: InstrValid=0 next cycle, PC=RedirectPC, go REQ; Redirect wins over simultaneous InstrReady.
REQ-025 Redirect while drop flag already set SHALL only update PC; still exactly one response discarded.
REQ-026 RedirectPC[1:0] SHALL be forced to 2'b00 when loaded into PC.
REQ-027 IMemRvalid in REQ or HOLD (no outstanding request) SHALL be ignored.

Reset
REQ-028 resetl=0 SHALL asynchronously set state REQ, PC=RESET_PC, drop flag=0, InstrValid=0, Instr=0, InstrPC=0, MisalignErr=0.
REQ-029 IMemReq SHALL be 0 while resetl=0 and assert on first rising CLK edge after release.
REQ-030 Reset mid-WAIT SHALL abandon the outstanding request; any later stray Rvalid is ignored per REQ-027.

Configuration
REQ-031 Macro FETCH_ALIGN_CHECK_EN SHALL enable misalignment checking.
REQ-032 Defined: Redirect with RedirectPC[1:0]!=0 SHALL set MisalignErr=1 (sticky until reset) and stop new requests (stay REQ with IMemReq=0) once any outstanding response is drained.
REQ-033 Undefined: behaviour per REQ-026 only.
REQ-034 Undefined: MisalignErr port SHALL still exist, tied to 0.

Structure
REQ-035 Shared package SHALL hold state enum (REQ/WAIT/HOLD), INSTR_W=32, PC_W=64, PC_INC=4.
REQ-036 Output holding register SHALL be sub-module fetch_outbuf (load, clear, valid, data, pc).

Verification
REQ-037 Reset release, RESET_PC=0x1000, Gnt same cycle, Rvalid next with 0xD503201F -> Instr=0xD503201F, InstrPC=0x1000, next IMemAddr=0x1004.
REQ-038 InstrReady=0 for 5 cycles in HOLD -> Instr/InstrPC stable, IMemReq=0 throughout.
REQ-039 Redirect to 0x2000 in WAIT, then Rvalid 0xAAAAAAAA -> no InstrValid; next IMemAddr=0x2000.
REQ-040 Redirect to 0x3000 with InstrReady=1 in HOLD -> InstrValid=0, next IMemAddr=0x3000.
REQ-041 PC=0xFFFF_FFFF_FFFF_FFFC fetch -> next IMemAddr=0x0.
REQ-042 With FETCH_ALIGN_CHECK_EN, Redirect to 0x2002 -> MisalignErr=1, IMemReq stays 0; without, next IMemAddr=0x2000.
